// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if
// CPU data port plus the BRAM port-A signals that the bridge sits between.
//
// Signal summary:
//   cpu_addr   CPU address
//   cpu_we     CPU write strobe
//   cpu_re     CPU read strobe
//   cpu_wdata  CPU write data
//   cpu_rdata  read data returned to the CPU
//   mem_q      BRAM port A read data
//   mem_we     BRAM write enable, gated by the bridge
//
// Handshake: there is no valid/ready pair. cpu_we and cpu_re are single-cycle
// strobes that qualify cpu_addr/cpu_wdata in the cycle they are high; the bus
// never stalls. cpu_rdata belongs to the address presented one cycle earlier,
// for both BRAM and I/O reads.
//
// Modports:
//   master  CPU/BRAM side: drives address, strobes, write data and mem_q
//   slave   bridge side: drives cpu_rdata and mem_we
interface mmio_bridge_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10
) ();
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_we;
  logic                  cpu_re;
  logic [WIDTH-1:0]      cpu_wdata;
  logic [WIDTH-1:0]      cpu_rdata;
  logic [WIDTH-1:0]      mem_q;
  logic                  mem_we;

  modport master (
    output cpu_addr, cpu_we, cpu_re, cpu_wdata, mem_q,
    input  cpu_rdata, mem_we
  );

  modport slave (
    input  cpu_addr, cpu_we, cpu_re, cpu_wdata, mem_q,
    output cpu_rdata, mem_we
  );
endinterface

// File: rtl/mmio_bridge.sv
// mmio_bridge
// Memory-mapped I/O bridge between the CPU data port and BRAM port A.
// The top quarter of the address space (addr[MSB:MSB-1] == 2'b11) is I/O;
// I/O writes never reach the BRAM. Offsets (addr[3:0]) inside the I/O region:
//   0..NUM_OUT-1  OUT[i] output registers, read/write
//   0xC           KBD_DATA: read returns FIFO head (0 if empty), read strobe pops
//   0xD           KBD_STATUS: [15] overflow (sticky, any write clears),
//                 [14] full, [13] empty, [8:0] count
//   others        read 0, writes ignored
// Read data has one cycle of latency on both paths so the CPU sees a single
// uniform read timing that matches the BRAM.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   bus        mmio_bridge_if.slave (CPU port + BRAM port A)
//   key_valid  one-cycle scancode strobe
//   key_code   scancode
//   out_regs   output registers, OUT[i] at [i*WIDTH +: WIDTH]
//   kbd_avail  keyboard buffer non-empty
//
// Build option: define MMIO_KBD_FIFO_EN for a FIFO_DEPTH-entry keyboard FIFO;
// without it the keyboard buffer is a single holding register (depth 1) and
// FIFO_DEPTH is ignored. WIDTH must be at least 16 for the status layout.
module mmio_bridge #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_OUT    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int KEY_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  mmio_bridge_if.slave             bus,
  input  logic                     key_valid,
  input  logic [KEY_WIDTH-1:0]     key_code,
  output logic [NUM_OUT*WIDTH-1:0] out_regs,
  output logic                     kbd_avail
);

  localparam logic [3:0] OFF_KBD_DATA = 4'hC;
  localparam logic [3:0] OFF_KBD_STAT = 4'hD;

  // ---------------- address decode ----------------
  logic       w_io_hit;
  logic [3:0] w_offset;
  logic       w_kbd_rd;
  logic       w_stat_wr;
  logic       w_unused_addr;

  assign w_io_hit  = (bus.cpu_addr[ADDR_WIDTH-1 -: 2] == 2'b11);
  assign w_offset  = bus.cpu_addr[3:0];
  assign w_kbd_rd  = w_io_hit & bus.cpu_re & (w_offset == OFF_KBD_DATA);
  assign w_stat_wr = w_io_hit & bus.cpu_we & (w_offset == OFF_KBD_STAT);
  // Middle address bits are not decoded: the 16 I/O offsets alias across the region.
  assign w_unused_addr = ^bus.cpu_addr[ADDR_WIDTH-3:4];

  assign bus.mem_we = bus.cpu_we & ~w_io_hit;

  // ---------------- keyboard buffer ----------------
  logic                 w_empty;
  logic                 w_full;
  logic [KEY_WIDTH-1:0] w_head;
  logic [8:0]           w_count;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_ovf_set;

  // A pop on an empty buffer is ignored. A full buffer still accepts a new
  // code when a pop frees a slot in the same cycle; otherwise the code is lost.
  assign w_pop     = w_kbd_rd & ~w_empty;
  assign w_push    = key_valid & (~w_full | w_pop);
  assign w_ovf_set = key_valid & w_full & ~w_pop;

`ifdef MMIO_KBD_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [KEY_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [8:0]           r_count;

  assign w_empty = (r_count == 9'd0);
  assign w_full  = (r_count == 9'(FIFO_DEPTH));
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_count = r_count;

  // Storage needs no reset: contents are only visible through the count.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo[r_wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 9'd1;
        2'b01:   r_count <= r_count - 9'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  localparam int UNUSED_FIFO_DEPTH = FIFO_DEPTH;

  logic [KEY_WIDTH-1:0] r_hold;
  logic                 r_hold_vld;

  assign w_empty = ~r_hold_vld;
  assign w_full  = r_hold_vld;
  assign w_head  = r_hold;
  assign w_count = {8'd0, r_hold_vld};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      // Covers push-with-pop on a full holder: the old code leaves, new one lands.
      r_hold     <= key_code;
      r_hold_vld <= 1'b1;
    end else if (w_pop) begin
      r_hold_vld <= 1'b0;
    end
  end
`endif

  assign kbd_avail = ~w_empty;

  // ---------------- registers ----------------
  logic [WIDTH-1:0] r_out [NUM_OUT];
  logic             r_ovf;
  logic             r_io_sel;
  logic [WIDTH-1:0] r_io_rdata;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[g*WIDTH +: WIDTH] = r_out[g];
  end

  // ---------------- I/O read mux ----------------
  logic [WIDTH-1:0] w_status;
  logic [WIDTH-1:0] w_rd_val;

  always_comb begin
    w_status      = '0;
    w_status[15]  = r_ovf;
    w_status[14]  = w_full;
    w_status[13]  = w_empty;
    w_status[8:0] = w_count;
  end

  // Head is taken before the pop that happens at the same edge.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (w_offset == 4'(i)) w_rd_val = r_out[i];
    end
    if (w_offset == OFF_KBD_DATA && !w_empty) w_rd_val = WIDTH'(w_head);
    if (w_offset == OFF_KBD_STAT)             w_rd_val = w_status;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_io_sel   <= 1'b0;
      r_io_rdata <= '0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) r_out[i] <= '0;
    end else begin
      r_io_sel   <= w_io_hit;
      r_io_rdata <= w_rd_val;
      // A new overflow wins over a clear in the same cycle.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_stat_wr) r_ovf <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_io_hit && bus.cpu_we && w_offset == 4'(i)) r_out[i] <= bus.cpu_wdata;
      end
    end
  end

  assign bus.cpu_rdata = r_io_sel ? r_io_rdata : bus.mem_q;

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;
  localparam int W      = 16;
  localparam int AW     = 10;
  localparam int NOUT   = 2;
  localparam int KW     = 8;
`ifdef MMIO_KBD_FIFO_EN
  localparam int DEPTH  = 8;
`else
  localparam int DEPTH  = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 key_valid = 1'b0;
  logic [KW-1:0]        key_code  = '0;
  logic [NOUT*W-1:0]    out_regs;
  logic                 kbd_avail;
  logic                 rd_issued = 1'b0;

  mmio_bridge_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mmio_bridge #(
    .WIDTH(W), .ADDR_WIDTH(AW), .NUM_OUT(NOUT), .FIFO_DEPTH(8), .KEY_WIDTH(KW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .key_valid (key_valid),
    .key_code  (key_code),
    .out_regs  (out_regs),
    .kbd_avail (kbd_avail)
  );

  // Behavioural BRAM: one-cycle synchronous read, read-before-write.
  logic [W-1:0] bram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = '0;
  end
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.cpu_addr] <= bus.cpu_wdata;
    bus.mem_q <= bram[bus.cpu_addr];
  end

  // ---------------- reference model ----------------
  logic [W-1:0]  ref_mem [1024];
  logic [W-1:0]  ref_out [NOUT];
  logic [KW-1:0] ref_fifo [$];
  logic          ref_ovf;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    for (int i = 0; i < NOUT; i++) ref_out[i] = '0;
    ref_ovf = 1'b0;
  end

  function automatic logic [W-1:0] model_status();
    int n;
    n = ref_fifo.size();
    return {ref_ovf, (n == DEPTH), (n == 0), 4'b0000, 9'(n)};
  endfunction

  function automatic logic [W-1:0] model_read(input logic [AW-1:0] a);
    int off;
    off = int'(a[3:0]);
    if (a[AW-1:AW-2] != 2'b11) return ref_mem[a];
    if (off < NOUT)            return ref_out[off];
    if (off == 12)             return (ref_fifo.size() > 0) ? W'(ref_fifo[0]) : '0;
    if (off == 13)             return model_status();
    return '0;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read data belongs to the read presented during the cycle ending at this edge.
  always @(posedge clk) begin
    if (rd_issued) begin
      #2;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL cpu_rdata: got %h with no expected entry at %0t", bus.cpu_rdata, $time);
      end else begin
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_state();
    #1;
    check("out_regs", out_regs, {ref_out[1], ref_out[0]});
    check("kbd_avail", 32'(kbd_avail), 32'(ref_fifo.size() != 0));
  endtask

  task automatic step(input logic [AW-1:0] a, input logic we, input logic re,
                      input logic [W-1:0] wd, input logic kv, input logic [KW-1:0] kc);
    logic io;
    logic pop;
    logic ovf_n;
    int   off;
    @(negedge clk);
    reset         = 1'b0;
    bus.cpu_addr  = a;
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_wdata = wd;
    key_valid     = kv;
    key_code      = kc;
    rd_issued     = re;
    io  = (a[AW-1:AW-2] == 2'b11);
    off = int'(a[3:0]);
    #1;
    check("mem_we", 32'(bus.mem_we), 32'(we & ~io));
    if (re) exp_q.push_back(model_read(a));
    // Model update: pop first, then a push lands if there is room.
    pop   = re && io && off == 12 && ref_fifo.size() > 0;
    ovf_n = ref_ovf;
    if (we && io && off == 13) ovf_n = 1'b0;
    if (pop) void'(ref_fifo.pop_front());
    if (kv) begin
      if (ref_fifo.size() < DEPTH) ref_fifo.push_back(kc);
      else ovf_n = 1'b1;
    end
    ref_ovf = ovf_n;
    if (we && io && off < NOUT) ref_out[off] = wd;
    if (we && !io) ref_mem[a] = wd;
    @(posedge clk);
    check_state();
  endtask

  task automatic do_reset(input logic kv);
    @(negedge clk);
    reset         = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_wdata = '0;
    rd_issued     = 1'b0;
    key_valid     = kv;
    key_code      = KW'($urandom);
    ref_fifo.delete();
    ref_ovf = 1'b0;
    for (int i = 0; i < NOUT; i++) ref_out[i] = '0;
    @(posedge clk);
    #1;
    check("rst_out_regs", out_regs, 32'h0);
    check("rst_kbd_avail", 32'(kbd_avail), 32'h0);
    check("rst_rdata_mem", 32'(bus.cpu_rdata), 32'(ref_mem[0]));
  endtask

  task automatic idle(input logic kv, input logic [KW-1:0] kc);
    step('0, 1'b0, 1'b0, '0, kv, kc);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(a, 1'b0, 1'b1, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    step(a, 1'b1, 1'b0, d, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    logic [3:0]    off;
    logic          kv;
    do_reset(1'b0);
    do_reset(1'b1);                    // scancode during reset is discarded
    rd(10'h30D);                       // status after reset: empty

    // Output registers and BRAM path
    wr(10'h300, 16'h00A5);
    wr(10'h301, 16'h5A00);
    check("out_regs_const", out_regs, 32'h5A00_00A5);
    rd(10'h301);
    wr(10'h010, 16'h1234);
    rd(10'h010);
    wr(10'h30E, 16'hBEEF);             // unmapped offset: ignored
    rd(10'h30E);

    // FIFO order and empty read
    idle(1'b1, 8'h1C);
    idle(1'b1, 8'h32);
    idle(1'b1, 8'h21);
    rd(10'h30D);
    for (int i = 0; i < 4; i++) rd(10'h30C);
    rd(10'h30D);

    // Overflow, clear, coincident push/pop on full, drain
    for (int i = 0; i < 9; i++) idle(1'b1, 8'(8'h40 + i));
    rd(10'h30D);
    wr(10'h30D, 16'h0000);
    rd(10'h30D);
    step(10'h30C, 1'b0, 1'b1, '0, 1'b1, 8'hAA);
    rd(10'h30D);
    for (int i = 0; i < 9; i++) rd(10'h30C);
    step(10'h30C, 1'b0, 1'b1, '0, 1'b1, 8'h77);   // empty: pop ignored, push lands
    rd(10'h30D);
    rd(10'h30C);

    // Reset with pending entries and a set output register
    idle(1'b1, 8'h01);
    idle(1'b1, 8'h02);
    idle(1'b1, 8'h03);
    wr(10'h300, 16'hFFFF);
    do_reset(1'b1);
    rd(10'h30D);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      kv  = ($urandom_range(0, 2) == 0);
      off = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 8))
        0: begin
          a = {2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, NOUT - 1))};
          step(a, 1'b1, 1'b0, W'($urandom), kv, KW'($urandom));
        end
        1: step({2'b11, 4'($urandom_range(0, 15)), off}, 1'b0, 1'b1, '0, kv, KW'($urandom));
        2: step(10'h30C, 1'b0, 1'b1, '0, kv, KW'($urandom));
        3: step(AW'($urandom_range(0, 15)), 1'b1, 1'b0, W'($urandom), kv, KW'($urandom));
        4: step(AW'($urandom_range(0, 15)), 1'b0, 1'b1, '0, kv, KW'($urandom));
        5: step({2'b11, 4'h0, off}, 1'b1, 1'b0, W'($urandom), kv, KW'($urandom));
        6: step(10'h30D, 1'b1, 1'b0, W'($urandom), kv, KW'($urandom));
        7: step(10'h30D, 1'b0, 1'b1, '0, kv, KW'($urandom));
        default: begin
          if ($urandom_range(0, 40) == 0) do_reset(kv);
          else idle(kv, KW'($urandom));
        end
      endcase
    end

    idle(1'b0, '0);
    idle(1'b0, '0);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory-mapped I/O bridge between the CPU data port and port A of the shared BRAM. It decodes the top quarter of the address space as an I/O region, holds NUM_OUT writable output registers (LED banks and similar), and buffers PS/2 scancodes in a FIFO that the CPU pops by reading. Read data is aligned to the one-cycle BRAM read latency, so the CPU sees one uniform read path.

## Interface
- WIDTH, 16, data word width
- ADDR_WIDTH, 10, CPU address width
- NUM_OUT, 2, number of output registers (1..12)
- FIFO_DEPTH, 8, keyboard FIFO entries (power of 2, 2..256)
- KEY_WIDTH, 8, scancode width (≤ WIDTH)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_we  in  1  CPU write strobe
- cpu_re  in  1  CPU read strobe (qualifies pop side effect)
- cpu_wdata  in  WIDTH  CPU write data
- cpu_rdata  out  WIDTH  read data to CPU, valid cycle after address
- mem_q  in  WIDTH  BRAM port A read data
- mem_we  out  1  gated BRAM write enable
- key_valid  in  1  one-cycle scancode strobe from keyboard decoder
- key_code  in  KEY_WIDTH  scancode
- out_regs  out  NUM_OUT*WIDTH  output registers, reg i at [i*WIDTH +: WIDTH]
- kbd_avail  out  1  FIFO non-empty

## Operation
- io_hit = cpu_addr[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b11; offset = cpu_addr[3:0].
- mem_we = cpu_we & ~io_hit (combinational); I/O writes never reach BRAM.
- Offsets 0..NUM_OUT-1: OUT[i], R/W; write on cpu_we & io_hit.
- Offset 0xC KBD_DATA: read returns zero-extended FIFO head; if cpu_re, pop. Empty: returns 0, no pop. Writes ignored.
- Offset 0xD KBD_STATUS: [15] overflow (sticky), [14] full, [13] empty, [8:0] count. Any write clears overflow.
- Other I/O offsets: read 0, writes ignored.
- Push on key_valid. Full and no pop in same cycle: code dropped, overflow set. Full with pop in same cycle: pop and push both occur, count unchanged, no overflow. Empty with push and pop: pop ignored, push occurs, read returns 0.
- Overflow clear and a new overflow in same cycle: overflow stays set.
- FIFO pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.

## Timing
- cpu_rdata: 1-cycle latency. At edge N the bridge registers io_hit and the I/O read value (head sampled before the pop at the same edge); in cycle N+1 cpu_rdata = registered I/O value if io_hit was registered, else mem_q.
- OUT writes visible on out_regs the cycle after the strobe edge.
- key_valid at edge N: kbd_avail high from N+1; status count reflects it for reads issued at N+1.
- Reset (synchronous, overrides all): out_regs = 0, FIFO empty, count 0, overflow 0, kbd_avail 0, registered select = memory (cpu_rdata = mem_q), registered I/O value 0. key_valid during reset is discarded. Reset mid-burst discards FIFO contents.

## Configuration
- MMIO_KBD_FIFO_EN defined: FIFO of FIFO_DEPTH as above.
- Not defined: FIFO replaced by single holding register (effective depth 1; full = valid); a new code while valid and not popped is dropped and sets overflow; FIFO_DEPTH ignored, count ∈ {0,1}. Register map and timing unchanged.

## Test plan
- Reset, then write 0x00A5 to addr 0x300, 0x5A00 to 0x301 -> out_regs = {0x5A00,0x00A5}, mem_we = 0 both cycles; read 0x301 -> cpu_rdata 0x5A00 one cycle later.
- Write 0x1234 to 0x010, read 0x010 -> mem_we pulse, cpu_rdata = mem_q (0x1234) next cycle.
- Push 0x1C, 0x32, 0x21; read 0x30C three times -> 0x001C, 0x0032, 0x0021; fourth read -> 0x0000, status empty bit set, kbd_avail 0.
- Push 9 codes with FIFO_DEPTH=8, no reads -> status = 0xC008 (overflow, full, count 8); write 0x30D -> status 0x4008; drained order = first 8 codes.
- Full FIFO, key_valid coincident with pop read -> returned oldest code, count stays 8, overflow stays 0.
- Reset asserted with 3 entries and OUT[0]=0xFFFF -> next cycle out_regs 0, status 0x2000, kbd_avail 0.
